rd_modport_fifo: RTL and testbench
==================================

// Module: rd_modport_fifo
// PURPOSE
//  Single-clock 32-entry FIFO exposing the read-side signal set used by the read driver/monitor
//  (read_enable, aempty_value, sw_rst in; read_data, rdempty, rd_almost_empty, underflow,
//  fifo_read_count, rd_level out), plus a minimal write port so the block can be filled.
//  Sits as the read-domain storage/status block under the read-agent bench.
// PARAMETERS
//  DATA_WIDTH  32  width of write_data/read_data
//  ADDR_WIDTH  5   log2(depth); depth = 2**ADDR_WIDTH = 32; count/level width = ADDR_WIDTH+1
// PORTS
//  rclk             in   1   sole clock, all state updates on posedge
//  hw_rst_n         in   1   reset, asynchronous, active-low
//  sw_rst           in   1   synchronous soft reset, active-high
//  write_enable     in   1   push request
//  write_data       in   32  push data
//  wfull            out  1   level==32 (combinational from registered level)
//  overflow         out  1   registered 1-cycle pulse: push attempted while full
//  read_enable      in   1   pop request
//  aempty_value     in   5   almost-empty threshold
//  read_data        out  32  registered pop data
//  rdempty          out  1   level==0
//  rd_almost_empty  out  1   level <= aempty_value (6-bit unsigned compare, threshold zero-extended)
//  underflow        out  1   registered 1-cycle pulse: pop attempted while empty
//  fifo_read_count  out  6   accepted pops since reset, modulo 64
//  rd_level         out  6   current occupancy 0..32
// BEHAVIOUR
//  - Reset (hw_rst_n=0, async): wr/rd pointers=0, rd_level=0, fifo_read_count=0, read_data=0,
//    underflow=0, overflow=0 => rdempty=1, rd_almost_empty=1, wfull=0. Memory not cleared.
//  - sw_rst=1 at posedge: same register values as hw reset; overrides read/write that cycle.
//  - Pointers 6-bit (ADDR_WIDTH+1); memory indexed by low 5 bits; wrap 31->0 is seamless.
//  - Push accepted iff write_enable && !wfull (level sampled before the edge); data stored at wr_ptr,
//    wr_ptr++. Push while full: dropped, overflow=1 next cycle.
//  - Pop accepted iff read_enable && !rdempty; read_data <= mem[rd_ptr] at that edge (1-cycle
//    latency, visible after the edge), rd_ptr++, fifo_read_count++ (wraps 63->0).
//    Pop while empty: read_data holds, no pointer/count change, underflow=1 next cycle.
//  - read_data holds its last value when no pop is accepted.
//  - Level update: +1 push only, -1 pop only, unchanged if both accepted or neither.
//  - Simultaneous push+pop when empty: push accepted, pop underflows; level becomes 1.
//  - Simultaneous push+pop when full: pop accepted, push rejected (overflow=1); level becomes 31.
//  - underflow/overflow are single-cycle pulses; they deassert the cycle after if not repeated.
//  - Flags derive combinationally from the registered level, so they change on the same edge
//    as rd_level; aempty_value changes affect rd_almost_empty immediately.
// TESTING
//  1 Reset: assert hw_rst_n=0 mid-traffic -> all outputs at reset values immediately, without waiting for a clock edge.
//  2 Fill/drain: push 0..31 -> wfull=1, rd_level=32; pop 32 -> read_data 0..31 in order,
//    rdempty=1, fifo_read_count=32.
//  3 Underflow: pop on empty -> underflow pulse 1 cycle, read_data/rd_level/count unchanged.
//  4 Almost-empty: aempty_value=4; levels 5->4 -> rd_almost_empty 0->1; set value 0 at level 4 -> 0.
//  5 Simultaneous ops: push+pop at level 0 -> level 1, underflow=1; at level 32 -> level 31, overflow=1.
//  6 sw_rst with 10 entries plus read_enable high -> next cycle level 0, count 0, read_data 0, rdempty=1.

Source files
------------

// File: rtl/rd_modport_fifo.sv
// Single-clock FIFO carrying the read-side status set (level, almost-empty, underflow,
// read count) plus a minimal write port so the storage can be filled.
module rd_modport_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  rclk,
    input  logic                  hw_rst_n,
    input  logic                  sw_rst,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  wfull,
    output logic                  overflow,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] aempty_value,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  rdempty,
    output logic                  rd_almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   fifo_read_count,
    output logic [ADDR_WIDTH:0]   rd_level
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         wr_ptr, rd_ptr;
    logic                  push_ok, pop_ok;

    // All flags come from the registered level so they move on the same edge as rd_level.
    assign wfull           = (rd_level == CW'(DEPTH));
    assign rdempty         = (rd_level == '0);
    assign rd_almost_empty = (rd_level <= {1'b0, aempty_value});
    assign push_ok         = write_enable && !wfull;
    assign pop_ok          = read_enable && !rdempty;

    // Storage is never cleared; a soft reset only suppresses the write.
    always_ff @(posedge rclk) begin
        if (push_ok && !sw_rst)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
    end

    always_ff @(posedge rclk or negedge hw_rst_n) begin
        if (!hw_rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_level        <= '0;
            fifo_read_count <= '0;
            read_data       <= '0;
            underflow       <= 1'b0;
            overflow        <= 1'b0;
        end else if (sw_rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            rd_level        <= '0;
            fifo_read_count <= '0;
            read_data       <= '0;
            underflow       <= 1'b0;
            overflow        <= 1'b0;
        end else begin
            underflow <= read_enable && rdempty;
            overflow  <= write_enable && wfull;
            if (push_ok)
                wr_ptr <= wr_ptr + CW'(1);
            if (pop_ok) begin
                read_data       <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                rd_ptr          <= rd_ptr + CW'(1);
                fifo_read_count <= fifo_read_count + CW'(1);
            end
            // Simultaneous accepted push and pop leave the level unchanged.
            case ({push_ok, pop_ok})
                2'b10:   rd_level <= rd_level + CW'(1);
                2'b01:   rd_level <= rd_level - CW'(1);
                default: rd_level <= rd_level;
            endcase
        end
    end
endmodule

// File: tb/tb_rd_modport_fifo.sv
// Directed bench for rd_modport_fifo: a queue-based reference checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_rd_modport_fifo;
    logic        rclk = 1'b0;
    logic        hw_rst_n = 1'b1;
    logic        sw_rst = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] write_data = '0;
    logic        read_enable = 1'b0;
    logic [4:0]  aempty_value = 5'd4;
    logic        wfull, overflow, rdempty, rd_almost_empty, underflow;
    logic [31:0] read_data;
    logic [5:0]  fifo_read_count, rd_level;

    int n_chk = 0;
    int n_fail = 0;

    // reference state
    logic [31:0] m_q[$];
    logic [31:0] m_rd = '0;
    logic [5:0]  m_cnt = '0;
    logic        m_uf = 1'b0, m_of = 1'b0;

    rd_modport_fifo dut (
        .rclk(rclk), .hw_rst_n(hw_rst_n), .sw_rst(sw_rst),
        .write_enable(write_enable), .write_data(write_data), .wfull(wfull), .overflow(overflow),
        .read_enable(read_enable), .aempty_value(aempty_value), .read_data(read_data),
        .rdempty(rdempty), .rd_almost_empty(rd_almost_empty), .underflow(underflow),
        .fifo_read_count(fifo_read_count), .rd_level(rd_level)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rd = '0; m_cnt = '0; m_uf = 1'b0; m_of = 1'b0;
    endtask

    // Apply one cycle of inputs, advance the reference at the edge, return shortly after.
    task automatic step(input logic we, input logic [31:0] wd, input logic re, input logic sr);
        bit full, empty;
        write_enable = we; write_data = wd; read_enable = re; sw_rst = sr;
        @(posedge rclk);
        if (sr) model_reset();
        else begin
            full  = (m_q.size() == 32);
            empty = (m_q.size() == 0);
            m_uf  = re && empty;
            m_of  = we && full;
            if (re && !empty) begin
                m_rd = m_q.pop_front();
                m_cnt = m_cnt + 6'd1;
            end
            if (we && !full) m_q.push_back(wd);
        end
        #1;
    endtask

    // Every-cycle comparison against the reference while out of hardware reset.
    always @(negedge rclk) begin
        if (hw_rst_n) begin
            chk("m_level",  32'(rd_level),        32'(m_q.size()));
            chk("m_rdata",  read_data,            m_rd);
            chk("m_count",  32'(fifo_read_count), 32'(m_cnt));
            chk("m_uf",     32'(underflow),       32'(m_uf));
            chk("m_of",     32'(overflow),        32'(m_of));
            chk("m_full",   32'(wfull),           32'(m_q.size() == 32));
            chk("m_empty",  32'(rdempty),         32'(m_q.size() == 0));
            chk("m_aempty", 32'(rd_almost_empty), 32'(m_q.size() <= int'(aempty_value)));
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, 32'(rd_level), 0);
        chk({tag, "_count"}, 32'(fifo_read_count), 0);
        chk({tag, "_rdata"}, read_data, 0);
        chk({tag, "_uf"}, 32'(underflow), 0);
        chk({tag, "_of"}, 32'(overflow), 0);
        chk({tag, "_empty"}, 32'(rdempty), 1);
        chk({tag, "_aempty"}, 32'(rd_almost_empty), 1);
        chk({tag, "_full"}, 32'(wfull), 0);
    endtask

    initial begin
        #1 hw_rst_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("por");
        @(negedge rclk); @(negedge rclk);
        hw_rst_n = 1'b1;
        @(posedge rclk); #1;

        // fill / drain across the pointer wrap
        for (int i = 0; i < 32; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("fill_full", 32'(wfull), 1);
        chk("fill_level", 32'(rd_level), 32);
        step(1'b1, 32'hDEAD, 1'b0, 1'b0);
        chk("push_full_of", 32'(overflow), 1);
        chk("push_full_level", 32'(rd_level), 32);
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 0, 1'b1, 1'b0);
            chk("drain_data", read_data, 32'(i));
        end
        chk("drain_empty", 32'(rdempty), 1);
        chk("drain_count", 32'(fifo_read_count), 32);

        // underflow
        step(1'b0, 0, 1'b1, 1'b0);
        chk("uf_pulse", 32'(underflow), 1);
        chk("uf_rdata", read_data, 31);
        chk("uf_count", 32'(fifo_read_count), 32);
        chk("uf_level", 32'(rd_level), 0);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("uf_clear", 32'(underflow), 0);

        // almost-empty threshold
        for (int i = 0; i < 5; i++) step(1'b1, 32'(10 + i), 1'b0, 1'b0);
        chk("ae_lvl5", 32'(rd_almost_empty), 0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("ae_lvl4", 32'(rd_almost_empty), 1);
        chk("ae_rdata", read_data, 10);
        aempty_value = 5'd0;
        #1 chk("ae_thr0", 32'(rd_almost_empty), 0);
        aempty_value = 5'd4;
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, 1'b0);
        chk("ae_drained", 32'(rdempty), 1);

        // simultaneous push+pop at empty and at full
        step(1'b1, 32'hA5, 1'b1, 1'b0);
        chk("sim0_level", 32'(rd_level), 1);
        chk("sim0_uf", 32'(underflow), 1);
        for (int i = 0; i < 31; i++) step(1'b1, 32'(200 + i), 1'b0, 1'b0);
        chk("sim_fill", 32'(wfull), 1);
        step(1'b1, 32'h999, 1'b1, 1'b0);
        chk("sim32_level", 32'(rd_level), 31);
        chk("sim32_of", 32'(overflow), 1);
        chk("sim32_rdata", read_data, 32'hA5);

        // soft reset with 10 entries and a pop pending
        for (int i = 0; i < 21; i++) step(1'b0, 0, 1'b1, 1'b0);
        chk("pre_sw_level", 32'(rd_level), 10);
        step(1'b1, 32'h77, 1'b1, 1'b1);
        chk_reset_vals("swrst");
        step(1'b0, 0, 1'b0, 1'b0);

        // asynchronous reset mid-traffic
        for (int i = 0; i < 5; i++) step(1'b1, 32'(50 + i), 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        write_enable = 1'b1; read_enable = 1'b1; write_data = 32'h55;
        #2 hw_rst_n = 1'b0;
        model_reset();
        #1 chk_reset_vals("async");
        write_enable = 1'b0; read_enable = 1'b0;
        @(negedge rclk);
        #2 hw_rst_n = 1'b1;
        @(posedge rclk); #1;
        step(1'b1, 32'h1234, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("post_rst_rdata", read_data, 32'h1234);
        step(1'b0, 0, 1'b0, 1'b0);
        @(negedge rclk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
